// File: rtl/axi_ram_burst_if.sv
// rtl/axi_ram_burst_if.sv - AXI4 slave port bundle for the burst RAM.
interface axi_ram_burst_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_ram_burst.sv
// rtl/axi_ram_burst.sv - AXI4 RAM slave with FIXED/INCR/WRAP bursts and independent read/write channels.
module axi_ram_burst #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic           clk,
    input  logic           rst,
    axi_ram_burst_if.slave s_axi
);
    localparam int         ADDR_LSB = $clog2(STRB_WIDTH);
    localparam int         DEPTH    = 2 ** (ADDR_WIDTH - ADDR_LSB);
    localparam logic [2:0] MAX_SIZE = 3'(ADDR_LSB);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    function automatic logic [2:0] clamp_size(input logic [2:0] s);
        return (s > MAX_SIZE) ? MAX_SIZE : s;
    endfunction

    function automatic logic is_illegal(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] sz,
                                        input logic [1:0] bt, input logic [7:0] ln);
        logic [ADDR_WIDTH-1:0] low;
        low = (ADDR_WIDTH'(1) << sz) - ADDR_WIDTH'(1);
        if (bt == 2'b11) return 1'b1;
        if (bt == 2'b10)
            return !(ln == 8'd1 || ln == 8'd3 || ln == 8'd7 || ln == 8'd15) || ((a & low) != '0);
        return 1'b0;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] sz,
                                                        input logic [1:0] bt, input logic [7:0] ln);
        logic [ADDR_WIDTH-1:0] step, mask;
        step = ADDR_WIDTH'(1) << sz;
        mask = ADDR_WIDTH'((32'(ln) + 32'd1) << sz) - ADDR_WIDTH'(1);
        case (bt)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | ((a + step) & mask);
            default: return (a & ~(step - ADDR_WIDTH'(1))) + step;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------- write channel ----------------
    w_state_t              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] w_addr_q;
    logic [7:0]            w_len_q, w_cnt_q;
    logic [2:0]            w_size_q;
    logic [1:0]            w_burst_q;
    logic [ID_WIDTH-1:0]   w_id_q;
    logic                  w_ill_q, w_err_q;
    logic                  awready, wready, bvalid, aw_hs, w_hs, mem_we;

    always_ff @(posedge clk) begin
        if (rst) w_state_q <= W_IDLE;
        else     w_state_q <= w_state_d;
    end

    // Ready/valid are gated by rst so every output reads 0 while reset is held.
    always_comb begin
        w_state_d = w_state_q;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        if (!rst) begin
            case (w_state_q)
                W_IDLE: begin
                    awready = 1'b1;
                    if (s_axi.awvalid) w_state_d = W_DATA;
                end
                W_DATA: begin
                    wready = 1'b1;
                    if (s_axi.wvalid && w_cnt_q == w_len_q) w_state_d = W_RESP;
                end
                W_RESP: begin
                    bvalid = 1'b1;
                    if (s_axi.bready) w_state_d = W_IDLE;
                end
                default: w_state_d = W_IDLE;
            endcase
        end
    end

    assign aw_hs  = awready && s_axi.awvalid;
    assign w_hs   = wready && s_axi.wvalid;
    assign mem_we = w_hs && !w_ill_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_id_q    <= '0;
            w_ill_q   <= 1'b0;
            w_err_q   <= 1'b0;
        end else begin
            if (aw_hs) begin
                w_addr_q  <= s_axi.awaddr;
                w_len_q   <= s_axi.awlen;
                w_cnt_q   <= '0;
                w_size_q  <= clamp_size(s_axi.awsize);
                w_burst_q <= s_axi.awburst;
                w_id_q    <= s_axi.awid;
                w_ill_q   <= is_illegal(s_axi.awaddr, clamp_size(s_axi.awsize), s_axi.awburst, s_axi.awlen);
                w_err_q   <= is_illegal(s_axi.awaddr, clamp_size(s_axi.awsize), s_axi.awburst, s_axi.awlen);
            end
            if (w_hs) begin
                w_addr_q <= next_addr(w_addr_q, w_size_q, w_burst_q, w_len_q);
                w_cnt_q  <= w_cnt_q + 8'd1;
                if (s_axi.wlast != (w_cnt_q == w_len_q)) w_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (s_axi.wstrb[i]) mem[w_addr_q[ADDR_WIDTH-1:ADDR_LSB]][8*i +: 8] <= s_axi.wdata[8*i +: 8];
            end
        end
    end

    assign s_axi.awready = awready;
    assign s_axi.wready  = wready;
    assign s_axi.bvalid  = bvalid;
    assign s_axi.bid     = bvalid ? w_id_q : '0;
    assign s_axi.bresp   = (bvalid && w_err_q) ? 2'b10 : 2'b00;

    // ---------------- read channel ----------------
    r_state_t              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [7:0]            r_len_q, r_cnt_q;
    logic [2:0]            r_size_q;
    logic [1:0]            r_burst_q;
    logic [ID_WIDTH-1:0]   r_id_q, rid_q;
    logic                  r_ill_q, arready, ar_hs, r_issue;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q, rvalid_q;

    always_ff @(posedge clk) begin
        if (rst) r_state_q <= R_IDLE;
        else     r_state_q <= r_state_d;
    end

    // A new AR waits until the last beat of the previous burst has drained.
    always_comb begin
        r_state_d = r_state_q;
        arready   = 1'b0;
        r_issue   = 1'b0;
        if (!rst) begin
            case (r_state_q)
                R_IDLE: begin
                    arready = !rvalid_q;
                    if (s_axi.arvalid && !rvalid_q) r_state_d = R_DATA;
                end
                R_DATA: begin
                    r_issue = !rvalid_q || s_axi.rready;
                    if (r_issue && r_cnt_q == r_len_q) r_state_d = R_IDLE;
                end
                default: r_state_d = R_IDLE;
            endcase
        end
    end

    assign ar_hs = arready && s_axi.arvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_id_q    <= '0;
            r_ill_q   <= 1'b0;
            rdata_q   <= '0;
            rid_q     <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            if (ar_hs) begin
                r_addr_q  <= s_axi.araddr;
                r_len_q   <= s_axi.arlen;
                r_cnt_q   <= '0;
                r_size_q  <= clamp_size(s_axi.arsize);
                r_burst_q <= s_axi.arburst;
                r_id_q    <= s_axi.arid;
                r_ill_q   <= is_illegal(s_axi.araddr, clamp_size(s_axi.arsize), s_axi.arburst, s_axi.arlen);
            end
            if (r_issue) begin
                rvalid_q <= 1'b1;
                rdata_q  <= r_ill_q ? '0 : mem[r_addr_q[ADDR_WIDTH-1:ADDR_LSB]];
                rresp_q  <= r_ill_q ? 2'b10 : 2'b00;
                rlast_q  <= (r_cnt_q == r_len_q);
                rid_q    <= r_id_q;
                r_addr_q <= next_addr(r_addr_q, r_size_q, r_burst_q, r_len_q);
                r_cnt_q  <= r_cnt_q + 8'd1;
            end else if (s_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign s_axi.arready = arready;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.rid     = rid_q;

    logic unused_sideband;
    assign unused_sideband = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot,
                               s_axi.arlock, s_axi.arcache, s_axi.arprot};
endmodule

// File: tb/tb_axi_ram_burst.sv
// tb/tb_axi_ram_burst.sv - scoreboard bench for axi_ram_burst against a byte-level memory model.
module tb_axi_ram_burst;
    logic clk;
    logic rst;

    axi_ram_burst_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)) bus ();

    axi_ram_burst #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .s_axi(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] data;
        logic [31:0] mask;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    b_exp_t      b_q[$];
    r_exp_t      r_q[$];
    logic [7:0]  model[int];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          rr_random = 0;
    bit          br_random = 0;
    logic [31:0] w_data[256];
    logic [3:0]  w_strb[256];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int eff_size(input logic [2:0] s);
        return (s > 3'd2) ? 2 : int'(s);
    endfunction

    function automatic bit model_illegal(input int a, input int len, input int sz, input int burst);
        int nb;
        nb = 1 << sz;
        if (burst == 3) return 1;
        if (burst == 2) return !(len == 1 || len == 3 || len == 7 || len == 15) || (a % nb != 0);
        return 0;
    endfunction

    // Byte address of beat n, straight from the AXI burst definitions.
    function automatic int beat_addr(input int a, input int len, input int sz, input int burst, input int n);
        int nb, total, base;
        nb = 1 << sz;
        if (burst == 0) return a;
        if (burst == 1) return (n == 0) ? a : ((a / nb) * nb + n * nb) % 65536;
        total = nb * (len + 1);
        base  = (a / total) * total;
        return base + ((a - base) + n * nb) % total;
    endfunction

    function automatic logic ready_of(input int which);
        case (which)
            0:       return bus.awready;
            1:       return bus.wready;
            default: return bus.arready;
        endcase
    endfunction

    task automatic wait_ready(input string name, input int which);
        int t;
        t = 0;
        @(negedge clk);
        while (!ready_of(which) && t < 2000) begin
            t++;
            @(negedge clk);
        end
        if (!ready_of(which)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: ready 0, expected 1", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] id, input int addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input bit bad_last, input int abort_beat);
        int sz, wa;
        bit ill;
        sz  = eff_size(size);
        ill = model_illegal(addr, len, sz, burst);
        bus.awid    = id;
        bus.awaddr  = addr[15:0];
        bus.awlen   = len[7:0];
        bus.awsize  = size;
        bus.awburst = burst;
        bus.awvalid = 1'b1;
        wait_ready("aw", 0);
        bus.awvalid = 1'b0;
        if (abort_beat < 0) b_q.push_back('{id: id, resp: (ill || bad_last) ? 2'b10 : 2'b00});
        for (int n = 0; n <= len; n++) begin
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
            bus.wdata  = w_data[n];
            bus.wstrb  = w_strb[n];
            bus.wlast  = (n == len) && !bad_last;
            bus.wvalid = 1'b1;
            if (n == abort_beat) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_comb_outputs", {bus.awready, bus.wready, bus.bvalid, bus.arready}, 4'b0);
                @(posedge clk);
                #1;
                rst        = 1'b0;
                bus.wvalid = 1'b0;
                bus.wlast  = 1'b0;
                return;
            end
            wait_ready("w", 1);
            bus.wvalid = 1'b0;
            bus.wlast  = 1'b0;
            if (!ill) begin
                wa = beat_addr(addr, len, sz, burst, n);
                for (int i = 0; i < 4; i++)
                    if (w_strb[n][i]) model[(wa / 4) * 4 + i] = w_data[n][8*i +: 8];
            end
        end
    endtask

    task automatic do_read(input logic [7:0] id, input int addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst);
        int sz, wa, ba;
        bit ill;
        r_exp_t e;
        sz  = eff_size(size);
        ill = model_illegal(addr, len, sz, burst);
        for (int n = 0; n <= len; n++) begin
            e.id   = id;
            e.last = (n == len);
            e.data = '0;
            e.mask = '0;
            if (ill) begin
                e.mask = 32'hFFFF_FFFF;
                e.resp = 2'b10;
            end else begin
                e.resp = 2'b00;
                wa = beat_addr(addr, len, sz, burst, n);
                for (int i = 0; i < 4; i++) begin
                    ba = (wa / 4) * 4 + i;
                    if (model.exists(ba)) begin
                        e.data[8*i +: 8] = model[ba];
                        e.mask[8*i +: 8] = 8'hFF;
                    end
                end
            end
            r_q.push_back(e);
        end
        bus.arid    = id;
        bus.araddr  = addr[15:0];
        bus.arlen   = len[7:0];
        bus.arsize  = size;
        bus.arburst = burst;
        bus.arvalid = 1'b1;
        wait_ready("ar", 2);
        bus.arvalid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((b_q.size() != 0 || r_q.size() != 0) && t < 3000) begin
            t++;
            @(posedge clk);
        end
        #1;
        check("drain_pending", 64'(b_q.size() + r_q.size()), 64'd0);
    endtask

    task automatic fill(input int n, input logic [31:0] first, input logic [31:0] step);
        for (int i = 0; i < n; i++) begin
            w_data[i] = first + step * 32'(i);
            w_strb[i] = 4'hF;
        end
    endtask

    // Ready drivers: fully open by default, random when a stall test asks for it.
    initial begin
        bus.rready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.rready = rr_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        bus.bready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.bready = br_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every handshake and watches for stall stability.
    initial begin
        b_exp_t      be;
        r_exp_t      re;
        bit          prev_stall;
        logic [43:0] prev_snap;
        prev_stall = 0;
        prev_snap  = '0;
        forever begin
            @(negedge clk);
            if (!rst && bus.bvalid && bus.bready) begin
                if (b_q.size() == 0) begin
                    check("b_unexpected", 64'd1, 64'd0);
                end else begin
                    be = b_q.pop_front();
                    check("bid", 64'(bus.bid), 64'(be.id));
                    check("bresp", 64'(bus.bresp), 64'(be.resp));
                end
            end
            if (!rst && bus.rvalid && bus.rready) begin
                if (r_q.size() == 0) begin
                    check("r_unexpected", 64'd1, 64'd0);
                end else begin
                    re = r_q.pop_front();
                    check("rdata", 64'(bus.rdata & re.mask), 64'(re.data & re.mask));
                    check("rid", 64'(bus.rid), 64'(re.id));
                    check("rresp", 64'(bus.rresp), 64'(re.resp));
                    check("rlast", 64'(bus.rlast), 64'(re.last));
                end
            end
            if (prev_stall && !rst)
                check("r_hold", 64'({bus.rvalid, bus.rlast, bus.rresp, bus.rid, bus.rdata}), 64'(prev_snap));
            prev_stall = !rst && bus.rvalid && !bus.rready;
            prev_snap  = {bus.rvalid, bus.rlast, bus.rresp, bus.rid, bus.rdata};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int addr, len, sz, bt, rbt;
        rst         = 1'b1;
        bus.awid    = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awlock  = 1'b0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata   = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.arid    = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arlock  = 1'b0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast,
                                    bus.bid, bus.rid, bus.rdata, bus.bresp, bus.rresp}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'({bus.awready, bus.arready}), 64'b11);
        @(posedge clk);
        #1;

        // INCR write then read back
        fill(4, 32'hA0, 32'h1);
        do_write(8'h5A, 'h10, 3, 3'd2, 2'b01, 0, -1);
        do_read(8'h3C, 'h10, 3, 3'd2, 2'b01);
        drain();

        // WRAP read starting mid-window
        fill(4, 32'h1, 32'h1);
        do_write(8'h01, 'h20, 3, 3'd2, 2'b01, 0, -1);
        do_read(8'h02, 'h28, 3, 3'd2, 2'b10);
        drain();

        // Narrow FIXED write into a known word
        fill(1, 32'hDEAD_BEEF, 32'h0);
        do_write(8'h03, 'h04, 0, 3'd2, 2'b01, 0, -1);
        w_data[0] = 32'h0000_0011; w_strb[0] = 4'h1;
        w_data[1] = 32'h0000_2200; w_strb[1] = 4'h2;
        do_write(8'h04, 'h04, 1, 3'd0, 2'b00, 0, -1);
        do_read(8'h05, 'h04, 0, 3'd2, 2'b01);
        drain();

        // Illegal bursts and framing errors
        fill(4, 32'h5555_0000, 32'h1);
        do_write(8'h06, 'h40, 3, 3'd2, 2'b01, 0, -1);
        fill(3, 32'hBAD0_0000, 32'h1);
        do_write(8'h07, 'h40, 2, 3'd2, 2'b10, 0, -1);
        fill(4, 32'hBAD1_0000, 32'h1);
        do_write(8'h08, 'h42, 3, 3'd2, 2'b10, 0, -1);
        fill(2, 32'h6666_0000, 32'h1);
        do_write(8'h09, 'h60, 1, 3'd2, 2'b01, 1, -1);
        do_read(8'h0A, 'h40, 3, 3'd2, 2'b01);
        do_read(8'h0B, 'h60, 1, 3'd2, 2'b01);
        do_read(8'h0C, 'h40, 3, 3'd2, 2'b11);
        drain();

        // Backpressured read alongside an independent write
        fill(8, 32'h8000_0000, 32'h11);
        do_write(8'h0D, 'h80, 7, 3'd2, 2'b01, 0, -1);
        drain();
        fill(8, 32'h2000_0000, 32'h101);
        rr_random = 1;
        br_random = 1;
        fork
            do_read(8'h0E, 'h80, 7, 3'd2, 2'b01);
            do_write(8'h0F, 'h200, 7, 3'd2, 2'b01, 0, -1);
        join
        drain();
        rr_random = 0;
        br_random = 0;
        do_read(8'h10, 'h200, 7, 3'd2, 2'b01);
        drain();

        // Reset during beat 2 of a 4-beat write
        fill(4, 32'h3000_0000, 32'h1);
        do_write(8'h11, 'h300, 3, 3'd2, 2'b01, 0, 2);
        @(negedge clk);
        check("awready_after_abort", 64'(bus.awready), 64'd1);
        check("rdata_after_abort", 64'(bus.rdata), 64'd0);
        repeat (4) begin
            check("no_bvalid_after_abort", 64'(bus.bvalid), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        do_read(8'h12, 'h300, 3, 3'd2, 2'b01);
        drain();

        // Randomized bursts over a scratch window
        for (int it = 0; it < 30; it++) begin
            addr = 'h400 + $urandom_range(0, 255);
            sz   = $urandom_range(0, 3);
            bt   = $urandom_range(0, 7);
            bt   = (bt < 3) ? 1 : (bt < 5) ? 2 : (bt < 7) ? 0 : 3;
            case ($urandom_range(0, 5))
                0: len = 0;
                1: len = 1;
                2: len = 3;
                3: len = 7;
                4: len = 15;
                default: len = $urandom_range(0, 15);
            endcase
            if (bt == 2 && $urandom_range(0, 3) != 0) addr = addr & ~((1 << eff_size(3'(sz))) - 1);
            for (int n = 0; n <= len; n++) begin
                w_data[n] = $urandom;
                w_strb[n] = 4'($urandom_range(0, 15));
            end
            rr_random = $urandom_range(0, 1);
            br_random = $urandom_range(0, 1);
            do_write(8'($urandom), addr, len, 3'(sz), 2'(bt), ($urandom_range(0, 7) == 0), -1);
            rbt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : bt;
            do_read(8'($urandom), addr, len, 3'(sz), 2'(rbt));
            drain();
        end
        rr_random = 0;
        br_random = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
